// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory path of single_cycle_processor.
// Provides the arbiter state encoding, the requester identifiers and the
// default address/data widths used by dmem_arbiter and rr_pick2.
package riscv_mem_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = IDLE,
    ST_ISSUE     = ISSUE,
    ST_WAIT_RESP = WAIT_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//   req0, req1  - request valids of requester 0 (core) and 1 (debug)
//   last_grant  - requester that won the previous arbitration
//   core_prio   - 1: requester 0 wins every tie
//   owner       - winning requester (valid when any=1)
//   any         - at least one request present
module rr_pick2
  import riscv_mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic core_prio,
  output logic owner,
  output logic any
);

  always_comb begin
    any   = req0 | req1;
    owner = REQ_CORE;
    if (req0 && req1) begin
      // On a tie the requester that did not win last time gets the port.
      owner = core_prio ? REQ_CORE : ~last_grant;
    end else if (req1) begin
      owner = REQ_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core load/store path
// (requester 0) and the debug/loader port (requester 1). One transaction is
// outstanding at a time; the winning request is captured into registers,
// issued to memory until accepted, and its response routed back. A response
// timeout produces an error response so a dead memory cannot hang a requester.
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN         - requester N request (held until gntN)
//   gntN                          - one-cycle pulse: request captured
//   rvalidN/rdataN/errN           - one-cycle response pulse, load data, timeout flag
//   m_req/m_we/m_addr/m_wdata     - memory request (stable until m_ready)
//   m_ready/m_rvalid/m_rdata      - memory accept, response valid, read data
//   stray                         - sticky: m_rvalid seen while no response was awaited
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = 16,
  parameter int CORE_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stray
);

  localparam int             CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic           PRIO_L   = (CORE_PRIO != 0);

  arb_state_e        state, state_nxt;
  logic              last_grant;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic pick_owner, pick_any;
  logic capture, accept, resp_ok, resp_to, resp_any;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .core_prio  (PRIO_L),
    .owner      (pick_owner),
    .any        (pick_any)
  );

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    resp_ok   = 1'b0;
    resp_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          capture   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_ready) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        // A real response in the last timeout cycle still beats the timeout.
        if (m_rvalid) begin
          resp_ok   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          resp_to   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign resp_any = resp_ok | resp_to;

  assign m_req   = (state == ST_ISSUE);
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= REQ_DBG;
      owner_q    <= REQ_CORE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      stray      <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt0    <= capture && (pick_owner == REQ_CORE);
      gnt1    <= capture && (pick_owner == REQ_DBG);
      rvalid0 <= resp_any && (owner_q == REQ_CORE);
      rvalid1 <= resp_any && (owner_q == REQ_DBG);

      if (capture) begin
        owner_q    <= pick_owner;
        last_grant <= pick_owner;
        we_q       <= (pick_owner == REQ_DBG) ? we1    : we0;
        addr_q     <= (pick_owner == REQ_DBG) ? addr1  : addr0;
        wdata_q    <= (pick_owner == REQ_DBG) ? wdata1 : wdata0;
      end

      // Counter only runs while waiting; cleared whenever WAIT_RESP is entered or left.
      if (accept || resp_any) begin
        cnt <= '0;
      end else if (state == ST_WAIT_RESP) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Stores and timeouts return zero data.
      if (resp_any && (owner_q == REQ_CORE)) begin
        rdata0 <= (resp_ok && !we_q) ? m_rdata : '0;
        err0   <= resp_to;
      end
      if (resp_any && (owner_q == REQ_DBG)) begin
        rdata1 <= (resp_ok && !we_q) ? m_rdata : '0;
        err1   <= resp_to;
      end

      if (m_rvalid && (state != ST_WAIT_RESP)) begin
        stray <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed transactions from both requesters
// against a bench memory responder, with a transaction-level reference model
// checked every cycle plus literal latency/data expectations.
module tb_dmem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [63:0] rdata0, rdata1;
  logic        m_req, m_we, m_ready, m_rvalid, stray;
  logic [63:0] m_addr, m_wdata, m_rdata;

  // second instance with CORE_PRIO=1 and an always-ready, always-responding memory
  logic        req0p, req1p;
  logic        gnt0p, gnt1p, rv0p, rv1p, e0p, e1p, mreqp, mwep, strayp;
  logic [63:0] rd0p, rd1p, maddrp, mwdatap;

  // bench controls for the memory responder
  logic        resp_en;
  logic        force_rvalid;
  int          stall_cfg;

  logic [63:0] mem    [256];
  logic [63:0] refmem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO), .CORE_PRIO(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .stray(stray)
  );

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO), .CORE_PRIO(1)) dut_prio (
    .clk(clk), .reset_n(reset_n),
    .req0(req0p), .we0(1'b0), .addr0(64'h0), .wdata0(64'h0),
    .req1(req1p), .we1(1'b0), .addr1(64'h8), .wdata1(64'h0),
    .gnt0(gnt0p), .gnt1(gnt1p), .rvalid0(rv0p), .rvalid1(rv1p),
    .rdata0(rd0p), .rdata1(rd1p), .err0(e0p), .err1(e1p),
    .m_req(mreqp), .m_we(mwep), .m_addr(maddrp), .m_wdata(mwdatap),
    .m_ready(1'b1), .m_rvalid(1'b1), .m_rdata(64'h0), .stray(strayp)
  );

  function automatic int idx(input logic [63:0] a);
    return int'(a[10:3]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: accepts after stall_cfg ISSUE cycles, answers two edges later.
  initial begin : responder
    int cd;
    int stall_left;
    bit in_issue;
    logic [63:0] rd_hold;
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    cd = 0; stall_left = 0; in_issue = 0; rd_hold = 64'h0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'h0;
    forever begin
      @(negedge clk);
      m_rvalid = 1'b0;
      m_ready  = 1'b0;
      if (!reset_n) begin
        cd = 0; in_issue = 0;
      end else begin
        if (force_rvalid) m_rvalid = 1'b1;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = rd_hold;
          end
        end
        if (m_req) begin
          if (!in_issue) begin
            in_issue   = 1;
            stall_left = stall_cfg;
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            m_ready  = 1'b1;
            in_issue = 0;
            if (m_we) mem[idx(m_addr)] = m_wdata;
            rd_hold = mem[idx(m_addr)];
            if (resp_en) cd = 2;
          end
        end
      end
    end
  end

  // Transaction-level reference model, stepped once per active edge.
  bit          md_busy, md_acc;
  int          md_own, md_last, md_edge, md_acc_edge;
  logic        md_we, md_stray;
  logic [63:0] md_addr, md_wd;
  logic        xg0, xg1, xv0, xv1, xe;
  logic [63:0] xd;

  task automatic mdl_reset();
    md_busy = 0; md_acc = 0; md_own = 0; md_last = 1; md_edge = 0; md_acc_edge = 0;
    md_we = 1'b0; md_addr = 64'h0; md_wd = 64'h0; md_stray = 1'b0;
    xg0 = 0; xg1 = 0; xv0 = 0; xv1 = 0; xe = 0; xd = 64'h0;
  endtask

  initial begin : compare
    int own;
    for (int i = 0; i < 256; i++) refmem[i] = 64'h0;
    mdl_reset();
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        mdl_reset();
      end else begin
        md_edge++;
        xg0 = 0; xg1 = 0; xv0 = 0; xv1 = 0;
        if (m_rvalid && !(md_busy && md_acc)) md_stray = 1'b1;
        if (!md_busy) begin
          if (req0 || req1) begin
            if (req0 && req1) own = 1 - md_last;
            else              own = req1 ? 1 : 0;
            md_own = own; md_last = own; md_busy = 1; md_acc = 0;
            md_we   = (own == 1) ? we1    : we0;
            md_addr = (own == 1) ? addr1  : addr0;
            md_wd   = (own == 1) ? wdata1 : wdata0;
            if (own == 0) xg0 = 1; else xg1 = 1;
          end
        end else if (!md_acc) begin
          if (m_ready) begin
            md_acc = 1;
            md_acc_edge = md_edge;
            if (md_we) refmem[idx(md_addr)] = md_wd;
          end
        end else if (m_rvalid || (md_edge - md_acc_edge == TO)) begin
          xe = !m_rvalid;
          xd = (m_rvalid && !md_we) ? refmem[idx(md_addr)] : 64'h0;
          if (md_own == 0) xv0 = 1; else xv1 = 1;
          md_busy = 0; md_acc = 0;
        end
        chk("gnt0", gnt0, xg0);
        chk("gnt1", gnt1, xg1);
        chk("rvalid0", rvalid0, xv0);
        chk("rvalid1", rvalid1, xv1);
        chk("m_req", m_req, md_busy && !md_acc);
        if (md_busy && !md_acc) begin
          chk("m_we", m_we, md_we);
          chk("m_addr", m_addr, md_addr);
          chk("m_wdata", m_wdata, md_wd);
        end
        if (xv0) begin
          chk("rdata0", rdata0, xd);
          chk("err0", err0, xe);
        end
        if (xv1) begin
          chk("rdata1", rdata1, xd);
          chk("err1", err1, xe);
        end
        chk("stray", stray, md_stray);
      end
    end
  end

  task automatic run_txn(input int id, input logic we, input logic [63:0] addr,
                         input logic [63:0] wd, input int budget,
                         output int gn, output int rn, output logic [63:0] rd,
                         output logic er, output logic s_we, output logic [63:0] s_addr,
                         output logic [63:0] s_wd);
    gn = -1; rn = -1; rd = 'x; er = 1'bx; s_we = 1'bx; s_addr = 'x; s_wd = 'x;
    @(negedge clk);
    if (id == 0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    else         begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #3;
      if (gn < 0 && ((id == 0) ? gnt0 : gnt1)) begin
        gn = k; s_we = m_we; s_addr = m_addr; s_wd = m_wdata;
        req0 = 0; req1 = 0;
      end
      if ((id == 0) ? rvalid0 : rvalid1) begin
        rn = k;
        rd = (id == 0) ? rdata0 : rdata1;
        er = (id == 0) ? err0 : err1;
        break;
      end
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int gn, rn, first;
    logic [63:0] rd, sa, swd;
    logic er, swe;
    int ord [4];
    int ordp [4];
    int g1p_cnt;
    int exp_rr [4];
    exp_rr = '{0, 1, 0, 1};

    reset_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 64'h0; addr1 = 64'h0; wdata0 = 64'h0; wdata1 = 64'h0;
    req0p = 0; req1p = 0;
    resp_en = 1'b1; force_rvalid = 1'b0; stall_cfg = 0;

    // reset state
    repeat (3) @(posedge clk);
    #3;
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_addr", m_addr, 64'h0);
    chk("rst_stray", stray, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // tie held from reset: round-robin on main DUT, fixed priority on dut_prio
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 64'h100; addr1 = 64'h108;
    req0p = 1; req1p = 1;
    for (int i = 0; i < 4; i++) begin ord[i] = -1; ordp[i] = -1; end
    g1p_cnt = 0;
    fork
      begin
        int got = 0;
        for (int n = 0; n < 60 && got < 4; n++) begin
          @(posedge clk);
          #3;
          if (gnt0) begin ord[got] = 0; got++; end
          else if (gnt1) begin ord[got] = 1; got++; end
        end
        req0 = 0; req1 = 0;
      end
      begin
        int gotp = 0;
        for (int n = 0; n < 60 && gotp < 4; n++) begin
          @(posedge clk);
          #3;
          if (gnt1p) g1p_cnt++;
          if (gnt0p) begin ordp[gotp] = 0; gotp++; end
          else if (gnt1p) begin ordp[gotp] = 1; gotp++; end
        end
        req0p = 0; req1p = 0;
      end
    join
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_order[%0d]", i), ord[i], exp_rr[i]);
      chk($sformatf("prio_order[%0d]", i), ordp[i], 0);
    end
    chk("prio_gnt1_count", g1p_cnt, 0);
    repeat (8) @(posedge clk);

    // debug preload then core load, zero-wait memory
    run_txn(1, 1'b1, 64'h100, 64'hDEADBEEFDEADBEEF, 40, gn, rn, rd, er, swe, sa, swd);
    chk("preload_err1", er, 1'b0);
    run_txn(0, 1'b0, 64'h100, 64'h0, 40, gn, rn, rd, er, swe, sa, swd);
    chk("load_gnt_latency", gn, 1);
    chk("load_rv_latency", rn, 4);
    chk("load_rdata0", rd, 64'hDEADBEEFDEADBEEF);
    chk("load_err0", er, 1'b0);

    // store acknowledge from the debug port
    run_txn(1, 1'b1, 64'h20, 64'h5, 40, gn, rn, rd, er, swe, sa, swd);
    chk("store_m_we", swe, 1'b1);
    chk("store_m_addr", sa, 64'h20);
    chk("store_m_wdata", swd, 64'h5);
    chk("store_rv_latency", rn, 4);
    chk("store_rdata1", rd, 64'h0);
    chk("store_err1", er, 1'b0);

    // backpressure: 5-cycle stall on a store, 20-cycle stall (beyond TIMEOUT) on a load
    stall_cfg = 5;
    run_txn(0, 1'b1, 64'h28, 64'hA5A5_0000_1234_5678, 60, gn, rn, rd, er, swe, sa, swd);
    chk("bp5_rv_latency", rn, 9);
    chk("bp5_err0", er, 1'b0);
    stall_cfg = 20;
    run_txn(0, 1'b0, 64'h28, 64'h0, 60, gn, rn, rd, er, swe, sa, swd);
    chk("bp20_rv_latency", rn, 24);
    chk("bp20_rdata0", rd, 64'hA5A5_0000_1234_5678);
    chk("bp20_err0", er, 1'b0);
    stall_cfg = 0;

    // timeout: memory accepts but never responds
    resp_en = 1'b0;
    run_txn(0, 1'b0, 64'h20, 64'h0, 40, gn, rn, rd, er, swe, sa, swd);
    chk("to_gnt_latency", gn, 1);
    chk("to_rv_latency", rn, 2 + TO);
    chk("to_rdata0", rd, 64'h0);
    chk("to_err0", er, 1'b1);
    chk("stray_before_late", stray, 1'b0);
    force_rvalid = 1'b1;
    @(negedge clk);
    #1;
    force_rvalid = 1'b0;
    @(posedge clk);
    #3;
    chk("stray_after_late", stray, 1'b1);

    // asynchronous reset while waiting for a response
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 64'h40;
    first = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #3;
      if (gnt0) begin first = n; break; end
    end
    req0 = 0;
    chk("rstmid_gnt_latency", first, 1);
    repeat (4) @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    chk("rstmid_m_req", m_req, 1'b0);
    chk("rstmid_m_addr", m_addr, 64'h0);
    chk("rstmid_err0", err0, 1'b0);
    chk("rstmid_stray", stray, 1'b0);
    chk("rstmid_rvalid0", rvalid0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #3;
      chk("rstmid_no_rvalid", rvalid0 | rvalid1, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    resp_en = 1'b1;

    // after reset a tie goes to requester 0 first
    req0 = 1; req1 = 1; addr0 = 64'h100; addr1 = 64'h108; we0 = 0; we1 = 0;
    first = -1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #3;
      if (gnt0) begin first = 0; break; end
      if (gnt1) begin first = 1; break; end
    end
    req0 = 0; req1 = 0;
    chk("post_reset_first_grant", first, 0);
    repeat (8) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
